soda_credit_ctrl: RTL and testbench
===================================

// Module: soda_credit_ctrl
// PURPOSE
//  Credit/price controller for the soda machine datapath. Holds the programmed price and the inserted credit.
//  Decides when to vend, holds the dispense request for a timed window, then pays out change one coin per tick.
//  Driven by the wrapper FSM strobes (cost_add, coins_add) and pb0 abort; its disp_req feeds the wrapper's disp input.
// PARAMETERS
//  W             10   width of price/credit registers (cents)
//  PRICE_DEFAULT 75   price loaded at reset
//  PRICE_MAX     995  largest programmable price; must be a multiple of 5
//  COST_STEP     5    price increment per cost_add strobe
//  VEND_TICKS    4    number of tick pulses disp_req stays high
//  CHANGE_COIN   5    value returned per change_pulse
// PORTS
//  clk          in   1   system clock
//  nrst         in   1   asynchronous active-low reset
//  tick         in   1   1-cycle timing enable from the shared counter
//  clr          in   1   abort/refund request (pb0), level
//  cost_add     in   1   1-cycle strobe: raise price by COST_STEP
//  coins_add    in   1   1-cycle strobe: insert coin selected by coin_sel
//  coin_sel     in   2   00=5, 01=10, 10=25, 11=100 cents
//  price        out  W   current price
//  credit       out  W   current credit
//  disp_req     out  1   dispense request to wrapper FSM
//  change_pulse out  1   1-cycle pulse per CHANGE_COIN returned
//  coin_reject  out  1   1-cycle pulse: coin not accepted
//  busy         out  1   high in VEND or CHANGE
// BEHAVIOUR
//  Reset (async, nrst=0)
//  - Outputs: price=PRICE_DEFAULT, credit=0; disp_req, change_pulse, coin_reject, busy all 0.
//  - state=IDLE; tick count=0.
//  - Reset mid-VEND/CHANGE abandons the operation with no further pulses.
//  Output timing
//  - All outputs are registered.
//  - An accepted coin updates credit on the next clock edge.
//  States (one-hot): IDLE, COLLECT, VEND, CHANGE.
//  IDLE (credit==0)
//  - cost_add: price+=COST_STEP; a result >PRICE_MAX wraps to COST_STEP.
//  - Accepted coin -> COLLECT.
//  COLLECT
//  - cost_add is ignored; price is locked while credit!=0.
//  - Registered credit>=price -> VEND on the next edge. Coins arriving in that same cycle are rejected.
//  - clr=1 -> CHANGE (full refund). clr together with coins_add: clr wins and the coin is rejected.
//  Coin acceptance
//  - Accept only in IDLE/COLLECT, only when credit+coin <= 2^W-1.
//  - Otherwise pulse coin_reject for 1 cycle; credit is unchanged.
//  VEND
//  - disp_req=1 from entry until VEND_TICKS tick pulses have been counted, then disp_req=0.
//  - On that exit edge: credit-=price. Go to CHANGE if the remainder is >0, else IDLE.
//  - clr is ignored (vend is committed). coins_add is rejected.
//  CHANGE
//  - Each tick: change_pulse=1 for that cycle and credit-=CHANGE_COIN.
//  - When credit reaches 0 -> IDLE. coins_add is rejected; clr is ignored.
//  Arithmetic
//  - Unsigned, W bits. price and credit are always multiples of 5, so change never underflows.
//  - Compare credit>=price at full width.
//  Other rules
//  - tick and cost_add in the same cycle are independent events.
//  - busy = VEND|CHANGE.
// STRUCTURE
//  Shared package soda_pkg:
//  - coin value constants COIN_5/10/25/100.
//  - coin_sel decode function.
//  - state one-hot localparams (also consumed by the wrapper debug display).
//  One sub-module soda_tick_timer:
//  - counts tick pulses up to VEND_TICKS; start/clear input; done output.
//  - instantiated once for the VEND window.
// TESTING
//  1. Reset -> price=75, credit=0, disp_req=0, busy=0; cost_add x2 in IDLE -> price=85.
//  2. Price 75; coins 25,25,25 -> credit 75; VEND with disp_req high for exactly 4 ticks; 0 change_pulses; IDLE, credit=0.
//  3. Price 75; one coin 100 -> VEND 4 ticks, then exactly 5 change_pulses on consecutive ticks; credit=0, IDLE.
//  4. Coins 10,25 then clr -> CHANGE; 7 change_pulses; disp_req never asserted.
//  5. Price 995, cost_add in IDLE -> price=5. With credit=10, cost_add -> price unchanged.
//  6. coins_add during VEND -> coin_reject 1 cycle, credit unchanged. nrst low mid-VEND -> all outputs at reset values immediately.

Source files
------------

// File: rtl/soda_pkg.sv
// Shared definitions for the soda machine: coin values, coin_sel decode and
// the one-hot state encoding (also read by the wrapper debug display).
package soda_pkg;

    localparam logic [6:0] COIN_5   = 7'd5;
    localparam logic [6:0] COIN_10  = 7'd10;
    localparam logic [6:0] COIN_25  = 7'd25;
    localparam logic [6:0] COIN_100 = 7'd100;

    localparam int unsigned ST_W = 4;
    localparam logic [3:0] ST_IDLE    = 4'b0001;
    localparam logic [3:0] ST_COLLECT = 4'b0010;
    localparam logic [3:0] ST_VEND    = 4'b0100;
    localparam logic [3:0] ST_CHANGE  = 4'b1000;

    // Map the 2-bit coin selector onto its value in cents.
    function automatic logic [6:0] coin_value(input logic [1:0] sel);
        logic [6:0] val;
        case (sel)
            2'b00:   val = COIN_5;
            2'b01:   val = COIN_10;
            2'b10:   val = COIN_25;
            default: val = COIN_100;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/soda_credit_ctrl_if.sv
// Strobe/status bundle between the wrapper FSM (master) and the credit
// controller (slave).
interface soda_credit_ctrl_if #(
    parameter int W = 10
);
    logic         tick;
    logic         clr;
    logic         cost_add;
    logic         coins_add;
    logic [1:0]   coin_sel;
    logic [W-1:0] price;
    logic [W-1:0] credit;
    logic         disp_req;
    logic         change_pulse;
    logic         coin_reject;
    logic         busy;

    modport master (
        output tick, clr, cost_add, coins_add, coin_sel,
        input  price, credit, disp_req, change_pulse, coin_reject, busy
    );

    modport slave (
        input  tick, clr, cost_add, coins_add, coin_sel,
        output price, credit, disp_req, change_pulse, coin_reject, busy
    );
endinterface

// File: rtl/soda_tick_timer.sv
// Counts tick pulses while enabled; done fires combinationally on the tick
// that completes the TICKS-long window so the owner can leave on that edge.
module soda_tick_timer #(
    parameter int TICKS = 4
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    input  logic tick,
    output logic done
);
    localparam int CW = (TICKS < 2) ? 1 : $clog2(TICKS);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign done = !clear && tick && (cnt_q == CW'(TICKS - 1));

    // Next count: held at zero while cleared, restarts after the window ends.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = done ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/soda_credit_ctrl.sv
// Price/credit controller: collects coins, commits a vend once credit covers
// the price, holds disp_req for a tick-timed window, then pays change out one
// coin per tick. All outputs come straight from flops.
module soda_credit_ctrl
    import soda_pkg::*;
#(
    parameter int W             = 10,
    parameter int PRICE_DEFAULT = 75,
    parameter int PRICE_MAX     = 995,
    parameter int COST_STEP     = 5,
    parameter int VEND_TICKS    = 4,
    parameter int CHANGE_COIN   = 5
) (
    input logic               clk,
    input logic               nrst,
    soda_credit_ctrl_if.slave bus
);
    logic [ST_W-1:0] state_q, state_d;
    logic [W-1:0]    price_q, price_d;
    logic [W-1:0]    credit_q, credit_d;
    logic            disp_req_q, disp_req_d;
    logic            change_pulse_q, change_pulse_d;
    logic            coin_reject_q, coin_reject_d;
    logic            busy_q, busy_d;

    logic            coin_accept;
    logic            vend_done;
    logic [W:0]      coin_ext;
    logic [W:0]      credit_sum;
    logic            coin_fits;
    logic [W:0]      price_inc;
    logic [W-1:0]    credit_after_vend;
    logic [W-1:0]    credit_after_coin;

    // Extra top bit on the sums catches overflow of the W-bit registers.
    assign coin_ext          = (W+1)'(coin_value(bus.coin_sel));
    assign credit_sum        = {1'b0, credit_q} + coin_ext;
    assign coin_fits         = !credit_sum[W];
    assign price_inc         = {1'b0, price_q} + (W+1)'(COST_STEP);
    assign credit_after_vend = credit_q - price_q;
    assign credit_after_coin = credit_q - W'(CHANGE_COIN);

    soda_tick_timer #(
        .TICKS (VEND_TICKS)
    ) u_vend_timer (
        .clk   (clk),
        .nrst  (nrst),
        .clear (state_q != ST_VEND),
        .tick  (bus.tick),
        .done  (vend_done)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_d        = state_q;
        price_d        = price_q;
        credit_d       = credit_q;
        disp_req_d     = disp_req_q;
        change_pulse_d = 1'b0;
        coin_accept    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cost_add) begin
                    price_d = (price_inc > (W+1)'(PRICE_MAX)) ? W'(COST_STEP)
                                                              : price_inc[W-1:0];
                end
                if (bus.coins_add && coin_fits) begin
                    coin_accept = 1'b1;
                    credit_d    = credit_sum[W-1:0];
                    state_d     = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // Price is locked here; an already-covered price wins over
                // both abort and any coin arriving in the same cycle.
                if (credit_q >= price_q) begin
                    state_d    = ST_VEND;
                    disp_req_d = 1'b1;
                end else if (bus.clr) begin
                    state_d = ST_CHANGE;
                end else if (bus.coins_add && coin_fits) begin
                    coin_accept = 1'b1;
                    credit_d    = credit_sum[W-1:0];
                end
            end
            ST_VEND: begin
                if (vend_done) begin
                    disp_req_d = 1'b0;
                    credit_d   = credit_after_vend;
                    state_d    = (credit_after_vend == '0) ? ST_IDLE : ST_CHANGE;
                end
            end
            ST_CHANGE: begin
                if (bus.tick) begin
                    change_pulse_d = 1'b1;
                    credit_d       = credit_after_coin;
                    if (credit_after_coin == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                // Illegal encoding: drop back to a clean idle.
                state_d    = ST_IDLE;
                credit_d   = '0;
                disp_req_d = 1'b0;
            end
        endcase

        coin_reject_d = bus.coins_add && !coin_accept;
        busy_d        = (state_d == ST_VEND) || (state_d == ST_CHANGE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= ST_IDLE;
            price_q        <= W'(PRICE_DEFAULT);
            credit_q       <= '0;
            disp_req_q     <= 1'b0;
            change_pulse_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            price_q        <= price_d;
            credit_q       <= credit_d;
            disp_req_q     <= disp_req_d;
            change_pulse_q <= change_pulse_d;
            coin_reject_q  <= coin_reject_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.price        = price_q;
    assign bus.credit       = credit_q;
    assign bus.disp_req     = disp_req_q;
    assign bus.change_pulse = change_pulse_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_soda_credit_ctrl.sv
// Directed bench for soda_credit_ctrl: reset, price stepping/wrap, exact vend,
// vend with change, abort refund, overflow reject, price lock, async reset.
module tb_soda_credit_ctrl;
    logic clk  = 1'b0;
    logic nrst = 1'b0;

    int total = 0;
    int bad   = 0;
    int n_chg  = 0;
    int n_disp = 0;

    soda_credit_ctrl_if #(.W(10)) bus_if ();

    soda_credit_ctrl dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    // Count change pulses and dispense-request cycles.
    always @(posedge clk) begin
        if (bus_if.change_pulse) n_chg <= n_chg + 1;
        if (bus_if.disp_req)     n_disp <= n_disp + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        step();
    endtask

    task automatic coin(input logic [1:0] sel);
        bus_if.coins_add = 1'b1;
        bus_if.coin_sel  = sel;
        step();
        bus_if.coins_add = 1'b0;
    endtask

    task automatic cost();
        bus_if.cost_add = 1'b1;
        step();
        bus_if.cost_add = 1'b0;
    endtask

    task automatic one_tick();
        bus_if.tick = 1'b1;
        step();
        bus_if.tick = 1'b0;
        step();
    endtask

    // Tick while disp_req is high; returns ticks spent (bounded).
    task automatic vend_ticks(output int n);
        n = 0;
        for (int i = 0; i < 40 && bus_if.disp_req; i++) begin
            one_tick();
            n++;
        end
    endtask

    // Tick while busy; bounded.
    task automatic drain();
        for (int i = 0; i < 60 && bus_if.busy; i++) begin
            one_tick();
        end
        step();
        step();
    endtask

    initial begin
        int c0, d0, nt;
        bus_if.tick      = 1'b0;
        bus_if.clr       = 1'b0;
        bus_if.cost_add  = 1'b0;
        bus_if.coins_add = 1'b0;
        bus_if.coin_sel  = 2'b00;
        #1;

        // 1: reset values, price stepping in IDLE
        step();
        chk("rst_price", bus_if.price, 75);
        chk("rst_credit", bus_if.credit, 0);
        chk("rst_disp", bus_if.disp_req, 0);
        chk("rst_busy", bus_if.busy, 0);
        nrst = 1'b1;
        step();
        cost();
        cost();
        chk("t1_price85", bus_if.price, 85);

        // 2: exact payment 25+25+25, late coin rejected, no change
        do_reset();
        coin(2'b10);
        chk("t2_credit25", bus_if.credit, 25);
        coin(2'b10);
        coin(2'b10);
        chk("t2_credit75", bus_if.credit, 75);
        coin(2'b00);
        chk("t2_late_reject", bus_if.coin_reject, 1);
        chk("t2_late_credit", bus_if.credit, 75);
        chk("t2_disp_on", bus_if.disp_req, 1);
        c0 = n_chg;
        vend_ticks(nt);
        chk("t2_vend_ticks", nt, 4);
        chk("t2_credit0", bus_if.credit, 0);
        chk("t2_busy0", bus_if.busy, 0);
        one_tick();
        one_tick();
        chk("t2_no_change", n_chg - c0, 0);

        // 3: 100 cents for 75 -> 5 change coins
        do_reset();
        coin(2'b11);
        chk("t3_credit100", bus_if.credit, 100);
        step();
        chk("t3_disp_on", bus_if.disp_req, 1);
        chk("t3_busy", bus_if.busy, 1);
        c0 = n_chg;
        vend_ticks(nt);
        chk("t3_vend_ticks", nt, 4);
        chk("t3_credit25", bus_if.credit, 25);
        chk("t3_busy_change", bus_if.busy, 1);
        drain();
        chk("t3_pulses", n_chg - c0, 5);
        chk("t3_credit0", bus_if.credit, 0);
        chk("t3_idle", bus_if.busy, 0);

        // 4: 10+25 then abort -> 7 change coins, no dispense
        do_reset();
        d0 = n_disp;
        coin(2'b01);
        coin(2'b10);
        chk("t4_credit35", bus_if.credit, 35);
        bus_if.clr = 1'b1;
        step();
        bus_if.clr = 1'b0;
        chk("t4_busy", bus_if.busy, 1);
        c0 = n_chg;
        drain();
        chk("t4_pulses", n_chg - c0, 7);
        chk("t4_credit0", bus_if.credit, 0);
        chk("t4_no_disp", n_disp - d0, 0);

        // 5: price to 995, overflow reject, vend, wrap, price lock
        do_reset();
        for (int i = 0; i < 184; i++) cost();
        chk("t5_price995", bus_if.price, 995);
        for (int i = 0; i < 9; i++) coin(2'b11);
        for (int i = 0; i < 3; i++) coin(2'b10);
        coin(2'b01);
        coin(2'b00);
        chk("t5_credit990", bus_if.credit, 990);
        coin(2'b11);
        chk("t5_ovf_reject", bus_if.coin_reject, 1);
        chk("t5_ovf_credit", bus_if.credit, 990);
        coin(2'b00);
        chk("t5_credit995", bus_if.credit, 995);
        step();
        vend_ticks(nt);
        chk("t5_vend_ticks", nt, 4);
        chk("t5_credit0", bus_if.credit, 0);
        chk("t5_busy0", bus_if.busy, 0);
        cost();
        chk("t5_wrap5", bus_if.price, 5);
        coin(2'b01);
        chk("t5_credit10", bus_if.credit, 10);
        step();
        do_reset();
        coin(2'b01);
        cost();
        chk("t5_locked", bus_if.price, 75);

        // 6: coin rejected during VEND, async reset mid-VEND
        do_reset();
        coin(2'b11);
        step();
        chk("t6_disp_on", bus_if.disp_req, 1);
        coin(2'b00);
        chk("t6_reject", bus_if.coin_reject, 1);
        chk("t6_credit", bus_if.credit, 100);
        step();
        chk("t6_reject_1cyc", bus_if.coin_reject, 0);
        #2;
        nrst = 1'b0;
        #1;
        chk("t6_ar_price", bus_if.price, 75);
        chk("t6_ar_credit", bus_if.credit, 0);
        chk("t6_ar_disp", bus_if.disp_req, 0);
        chk("t6_ar_busy", bus_if.busy, 0);
        chk("t6_ar_chg", bus_if.change_pulse, 0);
        step();
        nrst = 1'b1;
        c0 = n_chg;
        one_tick();
        one_tick();
        chk("t6_after_busy", bus_if.busy, 0);
        chk("t6_after_chg", n_chg - c0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
